// File: rtl/la_clkgate_ctrl_pkg.sv
// Shared types and widths for the idle-detect clock-gate enable controller.
package la_clkgate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    localparam int WAKE_CW  = 4;
    localparam int GATED_CW = 32;

endpackage

// File: rtl/la_satcnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module la_satcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/la_clkgate_ctrl.sv
// Idle-detect enable controller for an OR-style integrated clock gate.
// Define LA_CLKGATECTRL_STATS_EN to count cycles spent gated on gated_cnt.
module la_clkgate_ctrl
    import la_clkgate_ctrl_pkg::*;
#(
    parameter string PROP = "DEFAULT",
    parameter int    CW   = 8,
    parameter int    WAKE = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                req,
    input  logic                busy,
    input  logic                force_on,
    input  logic [CW-1:0]       idle_cycles,
    output logic                en,
    output logic                ready,
    output logic                gated,
    output logic [GATED_CW-1:0] gated_cnt
);

    localparam logic [WAKE_CW-1:0] WAKE_END = WAKE_CW'(WAKE);

    state_t               state;
    state_t               next_state;
    logic                 act;
    logic [CW-1:0]        idle_cnt;
    logic [WAKE_CW-1:0]   wake_cnt;
    logic                 en_d;
    logic                 ready_d;
    logic                 gated_d;

    assign act = req | busy | force_on;

    // Outputs are registered from the next state so the gate enable never glitches.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_RUN;
            en    <= 1'b1;
            ready <= 1'b1;
            gated <= 1'b0;
        end else begin
            state <= next_state;
            en    <= en_d;
            ready <= ready_d;
            gated <= gated_d;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_RUN: begin
                if (!act && (idle_cycles != '0)) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (act || (idle_cycles == '0)) next_state = ST_RUN;
                else if (idle_cnt >= idle_cycles) next_state = ST_OFF;
            end
            ST_OFF: begin
                if (act) next_state = ST_WAKE;
            end
            ST_WAKE: begin
                if (wake_cnt >= WAKE_END) next_state = ST_RUN;
            end
            default: next_state = ST_RUN;
        endcase
    end

    always_comb begin
        en_d    = (next_state != ST_OFF);
        ready_d = (next_state == ST_RUN) || (next_state == ST_IDLE);
        gated_d = (next_state == ST_OFF);
    end

    // Both counters rest at zero outside their state, so entry loads 1.
    la_satcnt #(.W(CW)) u_idle_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (next_state != ST_IDLE),
        .inc    (next_state == ST_IDLE),
        .cnt    (idle_cnt)
    );

    la_satcnt #(.W(WAKE_CW)) u_wake_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (next_state != ST_WAKE),
        .inc    (next_state == ST_WAKE),
        .cnt    (wake_cnt)
    );

`ifdef LA_CLKGATECTRL_STATS_EN
    la_satcnt #(.W(GATED_CW)) u_gated_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr    (1'b0),
        .inc    (state == ST_OFF),
        .cnt    (gated_cnt)
    );
`else
    assign gated_cnt = '0;
`endif

endmodule
